// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract controller.
package nibble_serial_adder_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Requester-side handshake and operand/result bundle for nibble_serial_adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_fa4_mbit.sv
// 4-bit full-adder slice shared across all nibble steps.
module fa4_mbit (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a single 4-bit slice,
// LSB nibble first, with a registered carry linking the steps.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               cy_q, cy_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    logic [NIB_W-1:0]   nib_a, nib_b, slice_s;
    logic               slice_co;

    assign nib_a = opa_q[idx_q*NIB_W +: NIB_W];
    assign nib_b = opb_q[idx_q*NIB_W +: NIB_W];

    fa4_mbit u_slice (
        .s  (slice_s),
        .co (slice_co),
        .a  (nib_a),
        .b  (nib_b),
        .ci (cy_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cy_q    <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cy_q    <= cy_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cy_d    = cy_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Subtract as a + ~b + 1, so ci is irrelevant when sub=1.
                    opa_d   = bus.a;
                    opb_d   = bus.sub ? ~bus.b : bus.b;
                    cy_d    = bus.sub ? 1'b1 : bus.ci;
                    s_d     = '0;
                    co_d    = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                s_d[idx_q*NIB_W +: NIB_W] = slice_s;
                cy_d = slice_co;
                if (idx_q == IDX_W'(NIB - 1)) begin
                    // Flags are captured with the last nibble so they are valid alongside done.
                    co_d    = slice_co;
                    ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                              (slice_s[NIB_W-1] != opa_q[WIDTH-1]);
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16 (directed + random) and WIDTH=32 (random).
module tb_nibble_serial_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
    nibble_serial_adder_if #(.WIDTH(32)) bus32 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    nibble_serial_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } res_t;

    res_t q16[$];
    res_t q32[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cnt16 = 0, cnt32 = 0;
    int   acc16 = 0, acc32 = 0;
    int   dn16  = 0, dn32  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input int unsigned w, input logic [31:0] a,
                                   input logic [31:0] b, input logic sub, input logic ci);
        logic [32:0] full;
        logic [31:0] mask, am, beff;
        res_t        r;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am    = a & mask;
        beff  = (sub ? ~b : b) & mask;
        full  = {1'b0, am} + {1'b0, beff} + {32'h0, (sub ? 1'b1 : ci)};
        r.s   = full[31:0] & mask;
        r.co  = full[w];
        r.ovf = (am[w-1] == beff[w-1]) && (r.s[w-1] != am[w-1]);
        return r;
    endfunction

    // Reference timing: busy for NIB+1 cycles after an accepted start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt16 <= 0;
            q16.delete();
        end else if (cnt16 == 0) begin
            if (bus16.start === 1'b1) begin
                q16.push_back(model(16, {16'h0, bus16.a}, {16'h0, bus16.b}, bus16.sub, bus16.ci));
                cnt16 <= 5;
                acc16 <= acc16 + 1;
            end
        end else begin
            cnt16 <= cnt16 - 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt32 <= 0;
            q32.delete();
        end else if (cnt32 == 0) begin
            if (bus32.start === 1'b1) begin
                q32.push_back(model(32, bus32.a, bus32.b, bus32.sub, bus32.ci));
                cnt32 <= 9;
                acc32 <= acc32 + 1;
            end
        end else begin
            cnt32 <= cnt32 - 1;
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (rst_n) begin
            check_eq("busy16", {63'h0, bus16.busy}, {63'h0, cnt16 != 0});
            check_eq("done16", {63'h0, bus16.done}, {63'h0, cnt16 == 1});
            if (bus16.done === 1'b1) begin
                dn16 <= dn16 + 1;
                if (q16.size() == 0) begin
                    check_eq("sb16_pending", 64'(q16.size()), 64'd1);
                end else begin
                    r = q16.pop_front();
                    check_eq("s16", {48'h0, bus16.s}, {32'h0, r.s});
                    check_eq("co16", {63'h0, bus16.co}, {63'h0, r.co});
                    check_eq("ovf16", {63'h0, bus16.ovf}, {63'h0, r.ovf});
                end
            end
        end
    end

    always @(negedge clk) begin
        res_t r;
        if (rst_n) begin
            check_eq("busy32", {63'h0, bus32.busy}, {63'h0, cnt32 != 0});
            check_eq("done32", {63'h0, bus32.done}, {63'h0, cnt32 == 1});
            if (bus32.done === 1'b1) begin
                dn32 <= dn32 + 1;
                if (q32.size() == 0) begin
                    check_eq("sb32_pending", 64'(q32.size()), 64'd1);
                end else begin
                    r = q32.pop_front();
                    check_eq("s32", {32'h0, bus32.s}, {32'h0, r.s});
                    check_eq("co32", {63'h0, bus32.co}, {63'h0, r.co});
                    check_eq("ovf32", {63'h0, bus32.ovf}, {63'h0, r.ovf});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((cnt16 != 0 || cnt32 != 0) && k < 50) begin
            tick();
            k++;
        end
        if (cnt16 != 0 || cnt32 != 0) check_eq("idle_timeout", 64'(cnt16 + cnt32), 64'd0);
    endtask

    task automatic check_zero16(input string tag);
        check_eq({tag, "_busy"}, {63'h0, bus16.busy}, 64'd0);
        check_eq({tag, "_done"}, {63'h0, bus16.done}, 64'd0);
        check_eq({tag, "_s"},    {48'h0, bus16.s},    64'd0);
        check_eq({tag, "_co"},   {63'h0, bus16.co},   64'd0);
        check_eq({tag, "_ovf"},  {63'h0, bus16.ovf},  64'd0);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic ci, input logic [15:0] exp_s,
                         input logic exp_co, input logic exp_ovf);
        wait_idle();
        bus16.a     = a;
        bus16.b     = b;
        bus16.sub   = sub;
        bus16.ci    = ci;
        bus16.start = 1'b1;
        tick();
        // Scramble operands after the accepting edge; the DUT must have latched them.
        bus16.start = 1'b0;
        bus16.a     = 16'($urandom);
        bus16.b     = 16'($urandom);
        bus16.sub   = 1'($urandom);
        bus16.ci    = 1'($urandom);
        wait_idle();
        check_eq({tag, "_s"},   {48'h0, bus16.s},   {48'h0, exp_s});
        check_eq({tag, "_co"},  {63'h0, bus16.co},  {63'h0, exp_co});
        check_eq({tag, "_ovf"}, {63'h0, bus16.ovf}, {63'h0, exp_ovf});
    endtask

    initial begin
        int dn_before;
        int base16, base32, cyc;
        bus16.start = 1'b0; bus16.sub = 1'b0; bus16.ci = 1'b0; bus16.a = '0; bus16.b = '0;
        bus32.start = 1'b0; bus32.sub = 1'b0; bus32.ci = 1'b0; bus32.a = '0; bus32.b = '0;
        #12;
        check_zero16("rst16");
        check_eq("rst32_s", {32'h0, bus32.s}, 64'd0);
        rst_n = 1'b1;
        tick();

        run16("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run16("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("add_ovf", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        run16("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run16("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);

        // start held high with changing operands: accepts at cycles 0 and 6 only.
        wait_idle();
        dn_before = dn16;
        for (int i = 0; i < 10; i++) begin
            bus16.start = 1'b1;
            bus16.a     = 16'($urandom);
            bus16.b     = 16'($urandom);
            bus16.sub   = 1'($urandom);
            bus16.ci    = 1'($urandom);
            tick();
        end
        bus16.start = 1'b0;
        wait_idle();
        tick();
        check_eq("held_start_ops", 64'(dn16 - dn_before), 64'd2);

        // Asynchronous reset in the middle of RUN (idx=2).
        wait_idle();
        dn_before   = dn16;
        bus16.a     = 16'h1111;
        bus16.b     = 16'h2222;
        bus16.sub   = 1'b0;
        bus16.ci    = 1'b0;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_busy", {63'h0, bus16.busy}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero16("midrst");
        tick();
        check_zero16("midrst_hold");
        #3;
        rst_n = 1'b1;
        repeat (8) tick();
        check_eq("midrst_no_done", 64'(dn16 - dn_before), 64'd0);
        check_zero16("post_rst");
        run16("after_rst", 16'hABCD, 16'h1111, 1'b0, 1'b1, 16'hBCDF, 1'b0, 1'b0);

        // Random traffic on both widths; the scoreboard decides which starts are accepted.
        base16 = acc16;
        base32 = acc32;
        cyc    = 0;
        while ((acc16 < base16 + 1000 || acc32 < base32 + 1000) && cyc < 40000) begin
            bus16.start = ($urandom_range(3) != 0);
            bus16.a     = 16'($urandom);
            bus16.b     = 16'($urandom);
            bus16.sub   = 1'($urandom);
            bus16.ci    = 1'($urandom);
            bus32.start = ($urandom_range(3) != 0);
            bus32.a     = $urandom;
            bus32.b     = $urandom;
            bus32.sub   = 1'($urandom);
            bus32.ci    = 1'($urandom);
            tick();
            cyc++;
        end
        bus16.start = 1'b0;
        bus32.start = 1'b0;
        check_eq("rand16_ops_done", {63'h0, acc16 >= base16 + 1000}, 64'd1);
        check_eq("rand32_ops_done", {63'h0, acc32 >= base32 + 1000}, 64'd1);
        wait_idle();
        tick();
        check_eq("sb16_drained", 64'(q16.size()), 64'd0);
        check_eq("sb32_drained", 64'(q32.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle controller that performs WIDTH-bit add/subtract by sequencing one shared 4-bit full-adder slice, one nibble per clock, LSB nibble first. A registered carry links the nibbles. The block trades latency for area: one adder slice instead of a WIDTH-bit adder. It sits between a requester (start/busy/done handshake) and the result consumer.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
NIB, WIDTH/4, number of nibble steps (derived; not overridden).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only in IDLE.
sub  input  1  0 = add, 1 = subtract (a - b).
a  input  WIDTH  operand a.
b  input  WIDTH  operand b.
ci  input  1  carry in; used only when sub=0.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse when result is valid.
s  output  WIDTH  result.
co  output  1  carry out of MSB nibble.
ovf  output  1  signed overflow.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n). Reset forces state=IDLE, busy=0, done=0, s=0, co=0, ovf=0, step index=0, carry reg=0, operand regs=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at a clk edge latches a into opa_r. b_eff = sub ? ~b : b is latched into opb_r. Carry reg = sub ? 1 : ci. Clear s. Set idx=0. Go to RUN. start=0 keeps IDLE.
- RUN, each cycle:
  - The slice adds opa_r[4*idx+3:4*idx] + opb_r[4*idx+3:4*idx] + carry reg.
  - The sum nibble is written to s[4*idx+3:4*idx] and the slice carry-out goes to the carry reg.
  - idx increments. On idx=NIB-1, go to DONE.
- DONE: lasts exactly one cycle. done=1. co = final carry reg. ovf = (opa_r[MSB]==opb_r[MSB]) && (s[MSB]!=opa_r[MSB]). Next state is IDLE.
- Latency: start sampled at edge E0; done is high during the cycle after edge E0+NIB; s/co/ovf are valid from then on.
- Results hold in IDLE until the next accepted start. Accepting a start clears s, co and ovf on that edge.
- start is ignored while busy=1; no queuing. The requester must hold a/b/sub/ci only for the accepting edge.
- start=1 in the DONE cycle is ignored. start is accepted back-to-back from IDLE on the following cycle.
- Subtract: co=1 means no borrow (a >= b unsigned).
- Reset asserted mid-RUN aborts immediately with no done pulse. After reset release, the block sits in IDLE.
- idx width = clog2(NIB). idx never exceeds NIB-1; no wrap-around is reachable.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - NIB_W = 4.
- Sub-module: one instance of the existing 4-bit full-adder slice fa4_mbit (s[3:0], co, a[3:0], b[3:0], ci), driven by muxed nibbles of opa_r/opb_r and the carry reg.
- Controller FSM, idx counter and result register live in nibble_serial_adder.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FFF, sub=0, ci=0, start pulse -> done 5 cycles after start edge, s=0x2233, co=0, ovf=0; busy high for exactly 5 cycles.
- a=0xFFFF, b=0x0001, sub=0, ci=0 -> s=0x0000, co=1, ovf=0 (carry ripples through all 4 nibbles). Repeat with a=0x7FFF, b=0x0000, ci=1 -> s=0x8000, co=0, ovf=1.
- sub=1, a=0x0005, b=0x0007, ci=1 (must be ignored) -> s=0xFFFE, co=0, ovf=0. Then a=0x0007, b=0x0005 -> s=0x0002, co=1.
- start held high for 10 cycles with operands changing every cycle -> exactly two operations: first accepted at cycle 0, second at cycle 6 (first IDLE cycle). Each result matches the operands latched at its accept edge.
- Assert rst_n=0 asynchronously (mid-clock) during RUN at idx=2 -> all outputs 0 immediately, no done pulse. After release, a new start completes correctly.
- Randomized 1000 operations, WIDTH=16 and WIDTH=32, scoreboard against a+b_eff+cin -> s/co/ovf match; done pulses are always 1 cycle wide.
